// File: rtl/run_trace_pkg.sv
// Shared types and widths for the LEGv8 run controller and its trace buffer.
package run_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INSTR_W = 32;
  localparam int TRACE_W     = DEF_ADDR_W + DEF_INSTR_W;

endpackage

// File: rtl/run_trace_ctrl_trace_buffer.sv
// Circular trace FIFO, first-word-fall-through read, overwrite-oldest when full,
// sticky overflow flag and synchronous flush.
module trace_buffer #(
  parameter int W     = 64,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop;
  logic             full;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      // a write into a full buffer drops the oldest entry by advancing the read side
      if (pop || (wr_en && full)) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !pop && full) overflow <= 1'b1;
      if (wr_en && !pop && !full)
        count <= count + CNT_W'(1);
      else if (!wr_en && pop)
        count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/run_trace_ctrl.sv
// Run/step/halt sequencer for the single-cycle LEGv8 datapath with cycle counter and trace capture.
// Optional PC breakpoints are built when RUN_TRACE_BP_EN is defined.
//
// state | meaning
// IDLE  | cleared, waiting for start or step
// RUN   | free-running until stop, cycle limit or breakpoint
// STEP  | executes exactly one instruction
// HALT  | stopped, counter and trace retained
module run_trace_ctrl
  import run_trace_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int INSTR_W     = DEF_INSTR_W,
  parameter int CYC_W       = 16,
  parameter int TRACE_DEPTH = 16,
  parameter int NUM_BP      = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        step,
  input  logic                        stop,
  input  logic                        clear,
  input  logic [CYC_W-1:0]            max_cycles,
  input  logic [ADDR_W-1:0]           pc,
  input  logic [INSTR_W-1:0]          instruction,
  input  logic [NUM_BP*ADDR_W-1:0]    bp_addr,
  input  logic [NUM_BP-1:0]           bp_valid,
  output logic                        cpu_en,
  output logic [1:0]                  state,
  output logic [CYC_W-1:0]            cycle_count,
  output logic                        bp_hit,
  input  logic                        trace_rd_en,
  output logic [ADDR_W+INSTR_W-1:0]   trace_rd_data,
  output logic                        trace_empty,
  output logic [$clog2(TRACE_DEPTH):0] trace_count,
  output logic                        trace_overflow
);

  localparam int TW = ADDR_W + INSTR_W;

  state_t st;
  logic   bp_match;
  logic   limit_hit;

`ifdef RUN_TRACE_BP_EN
  logic              skip_bp;
  logic              bp_hit_q;
  logic [NUM_BP-1:0] bp_eq;

  always_comb begin
    bp_eq = '0;
    for (int i = 0; i < NUM_BP; i++)
      bp_eq[i] = bp_valid[i] && (pc == bp_addr[i*ADDR_W +: ADDR_W]);
  end

  assign bp_match = (st == ST_RUN) && !skip_bp && (|bp_eq);
  assign bp_hit   = bp_hit_q;

  // skip_bp lets the instruction that caused the halt execute on resume
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skip_bp  <= 1'b0;
      bp_hit_q <= 1'b0;
    end else if (clear) begin
      skip_bp  <= 1'b0;
      bp_hit_q <= 1'b0;
    end else begin
      skip_bp <= (st == ST_HALT) && start;
      if ((st == ST_RUN) && !stop && bp_match)
        bp_hit_q <= 1'b1;
      else if ((st == ST_HALT) && (start || step))
        bp_hit_q <= 1'b0;
    end
  end
`else
  logic unused_bp;
  assign unused_bp = ^{bp_addr, bp_valid};
  assign bp_match  = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  assign cpu_en    = ((st == ST_RUN) && !bp_match) || (st == ST_STEP);
  assign limit_hit = (st == ST_RUN) && cpu_en && (max_cycles != '0)
                     && (cycle_count >= max_cycles - CYC_W'(1));
  assign state     = st;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st          <= ST_IDLE;
      cycle_count <= '0;
    end else if (clear) begin
      st          <= ST_IDLE;
      cycle_count <= '0;
    end else begin
      if (cpu_en && (cycle_count != '1)) cycle_count <= cycle_count + CYC_W'(1);
      case (st)
        ST_IDLE, ST_HALT: begin
          if (start)     st <= ST_RUN;
          else if (step) st <= ST_STEP;
        end
        ST_RUN:  if (stop || bp_match || limit_hit) st <= ST_HALT;
        ST_STEP: st <= ST_HALT;
        default: st <= ST_IDLE;
      endcase
    end
  end

  trace_buffer #(
    .W     (TW),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clock    (clock),
    .reset    (reset),
    .flush    (clear),
    .wr_en    (cpu_en && !clear),
    .wr_data  ({pc, instruction}),
    .rd_en    (trace_rd_en),
    .rd_data  (trace_rd_data),
    .empty    (trace_empty),
    .count    (trace_count),
    .overflow (trace_overflow)
  );

endmodule

// File: tb/tb_run_trace_ctrl.sv
// Directed bench for run_trace_ctrl; breakpoint scenario follows RUN_TRACE_BP_EN.
module tb_run_trace_ctrl;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int CYC_W   = 16;
  localparam int DEPTH   = 16;
  localparam int NUM_BP  = 2;

  logic                        clock;
  logic                        reset;
  logic                        start, step, stop, clear;
  logic [CYC_W-1:0]            max_cycles;
  logic [ADDR_W-1:0]           pc;
  logic [INSTR_W-1:0]          instruction;
  logic [NUM_BP*ADDR_W-1:0]    bp_addr;
  logic [NUM_BP-1:0]           bp_valid;
  logic                        cpu_en;
  logic [1:0]                  state;
  logic [CYC_W-1:0]            cycle_count;
  logic                        bp_hit;
  logic                        trace_rd_en;
  logic [ADDR_W+INSTR_W-1:0]   trace_rd_data;
  logic                        trace_empty;
  logic [$clog2(DEPTH):0]      trace_count;
  logic                        trace_overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int en_cnt = 0;

  run_trace_ctrl #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CYC_W(CYC_W), .TRACE_DEPTH(DEPTH), .NUM_BP(NUM_BP)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .step(step), .stop(stop), .clear(clear),
    .max_cycles(max_cycles), .pc(pc), .instruction(instruction),
    .bp_addr(bp_addr), .bp_valid(bp_valid), .cpu_en(cpu_en), .state(state),
    .cycle_count(cycle_count), .bp_hit(bp_hit), .trace_rd_en(trace_rd_en),
    .trace_rd_data(trace_rd_data), .trace_empty(trace_empty),
    .trace_count(trace_count), .trace_overflow(trace_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return {16'hD000, p[15:0]};
  endfunction

  // Acts as the PC unit: PC advances by 4 after every cycle with cpu_en high.
  task automatic tick();
    logic en;
    en = cpu_en;
    @(posedge clock);
    #1;
    if (en) begin
      pc = pc + 32'd4;
      en_cnt++;
    end
    instruction = instr_of(pc);
    start = 1'b0; step = 1'b0; stop = 1'b0; clear = 1'b0; trace_rd_en = 1'b0;
    #1;
  endtask

  task automatic run_until_halt(input int budget);
    int g;
    g = 0;
    while (state !== 2'b11 && g < budget) begin
      tick();
      g++;
    end
    n_cmp++;
    if (state !== 2'b11) begin
      n_bad++;
      $display("FAIL halt_timeout state=%b required=11", state);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL rst_state got=%b exp=00", state); end
    n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_en got=%b exp=0", cpu_en); end
    n_cmp++; if (cycle_count !== 16'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", cycle_count); end
    n_cmp++; if (trace_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got=%b exp=1", trace_empty); end
    n_cmp++; if (trace_count !== 5'd0) begin n_bad++; $display("FAIL rst_tcount got=%0d exp=0", trace_count); end
    n_cmp++; if (trace_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got=%b exp=0", trace_overflow); end
    n_cmp++; if (bp_hit !== 1'b0) begin n_bad++; $display("FAIL rst_bphit got=%b exp=0", bp_hit); end
    // reset asserted in the middle of a run
    pc = 32'd0; instruction = instr_of(pc); max_cycles = 16'd0;
    start = 1'b1; tick(); tick(); tick(); tick();
    n_cmp++; if (cycle_count !== 16'd3) begin n_bad++; $display("FAIL mid_pre_count got=%0d exp=3", cycle_count); end
    reset = 1'b1;
    #2;
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL mid_rst_state got=%b exp=00", state); end
    n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL mid_rst_cpu_en got=%b exp=0", cpu_en); end
    n_cmp++; if (cycle_count !== 16'd0) begin n_bad++; $display("FAIL mid_rst_count got=%0d exp=0", cycle_count); end
    n_cmp++; if (trace_empty !== 1'b1) begin n_bad++; $display("FAIL mid_rst_empty got=%b exp=1", trace_empty); end
    @(posedge clock);
    #1 reset = 1'b0;
    pc = 32'd0; instruction = instr_of(pc);
    #1;
  endtask

  task automatic test_limit();
    logic [31:0] p;
    pc = 32'd0; instruction = instr_of(pc); max_cycles = 16'd5; en_cnt = 0;
    start = 1'b1; tick();
    run_until_halt(30);
    n_cmp++; if (en_cnt != 5) begin n_bad++; $display("FAIL lim_en_cycles got=%0d exp=5", en_cnt); end
    n_cmp++; if (cycle_count !== 16'd5) begin n_bad++; $display("FAIL lim_count got=%0d exp=5", cycle_count); end
    n_cmp++; if (trace_count !== 5'd5) begin n_bad++; $display("FAIL lim_tcount got=%0d exp=5", trace_count); end
    n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL lim_halt_en got=%b exp=0", cpu_en); end
    for (int i = 0; i < 5; i++) begin
      p = 32'(i * 4);
      n_cmp++;
      if (trace_rd_data !== {p, instr_of(p)}) begin
        n_bad++; $display("FAIL lim_pop%0d got=%h exp=%h", i, trace_rd_data, {p, instr_of(p)});
      end
      trace_rd_en = 1'b1; tick();
    end
    n_cmp++; if (trace_empty !== 1'b1) begin n_bad++; $display("FAIL lim_drained got=%b exp=1", trace_empty); end
    // limit already below the count: exactly one executed cycle
    max_cycles = 16'd3; en_cnt = 0;
    start = 1'b1; tick();
    run_until_halt(10);
    n_cmp++; if (en_cnt != 1) begin n_bad++; $display("FAIL lim_past_en got=%0d exp=1", en_cnt); end
    n_cmp++; if (cycle_count !== 16'd6) begin n_bad++; $display("FAIL lim_past_count got=%0d exp=6", cycle_count); end
    clear = 1'b1; tick();
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL clr_state got=%b exp=00", state); end
    n_cmp++; if (cycle_count !== 16'd0) begin n_bad++; $display("FAIL clr_count got=%0d exp=0", cycle_count); end
    n_cmp++; if (trace_empty !== 1'b1) begin n_bad++; $display("FAIL clr_empty got=%b exp=1", trace_empty); end
  endtask

  task automatic test_step();
    logic [31:0] p;
    pc = 32'h100; instruction = instr_of(pc); max_cycles = 16'd0; en_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; tick();
      n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL step%0d_state got=%b exp=10", k, state); end
      n_cmp++; if (cpu_en !== 1'b1) begin n_bad++; $display("FAIL step%0d_en got=%b exp=1", k, cpu_en); end
      tick();
      n_cmp++; if (state !== 2'b11) begin n_bad++; $display("FAIL step%0d_halt got=%b exp=11", k, state); end
      n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL step%0d_en_off got=%b exp=0", k, cpu_en); end
    end
    n_cmp++; if (en_cnt != 3) begin n_bad++; $display("FAIL step_en_cycles got=%0d exp=3", en_cnt); end
    n_cmp++; if (cycle_count !== 16'd3) begin n_bad++; $display("FAIL step_count got=%0d exp=3", cycle_count); end
    n_cmp++; if (trace_count !== 5'd3) begin n_bad++; $display("FAIL step_tcount got=%0d exp=3", trace_count); end
    for (int k = 0; k < 3; k++) begin
      p = 32'h100 + 32'(k * 4);
      n_cmp++;
      if (trace_rd_data !== {p, instr_of(p)}) begin
        n_bad++; $display("FAIL step_pop%0d got=%h exp=%h", k, trace_rd_data, {p, instr_of(p)});
      end
      trace_rd_en = 1'b1; tick();
    end
    trace_rd_en = 1'b1; tick();
    n_cmp++; if (trace_count !== 5'd0) begin n_bad++; $display("FAIL empty_pop_count got=%0d exp=0", trace_count); end
    n_cmp++; if (trace_empty !== 1'b1) begin n_bad++; $display("FAIL empty_pop_flag got=%b exp=1", trace_empty); end
    clear = 1'b1; tick();
  endtask

  task automatic test_overflow();
    pc = 32'd0; instruction = instr_of(pc); max_cycles = 16'd20;
    start = 1'b1; tick();
    run_until_halt(40);
    n_cmp++; if (cycle_count !== 16'd20) begin n_bad++; $display("FAIL ovf_count got=%0d exp=20", cycle_count); end
    n_cmp++; if (trace_count !== 5'd16) begin n_bad++; $display("FAIL ovf_tcount got=%0d exp=16", trace_count); end
    n_cmp++; if (trace_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b exp=1", trace_overflow); end
    n_cmp++;
    if (trace_rd_data !== {32'd16, instr_of(32'd16)}) begin
      n_bad++; $display("FAIL ovf_first_pop got=%h exp=%h", trace_rd_data, {32'd16, instr_of(32'd16)});
    end
    trace_rd_en = 1'b1; tick();
    n_cmp++; if (trace_count !== 5'd15) begin n_bad++; $display("FAIL ovf_after_pop got=%0d exp=15", trace_count); end
    n_cmp++; if (trace_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b exp=1", trace_overflow); end
    clear = 1'b1; tick();
    n_cmp++; if (trace_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_cleared got=%b exp=0", trace_overflow); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p;
    pc = 32'd0; instruction = instr_of(pc); max_cycles = 16'd0;
    start = 1'b1; tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      p = 32'(k * 4);
      n_cmp++;
      if (trace_rd_data !== {p, instr_of(p)}) begin
        n_bad++; $display("FAIL b2b_data%0d got=%h exp=%h", k, trace_rd_data, {p, instr_of(p)});
      end
      trace_rd_en = 1'b1; tick();
      n_cmp++; if (trace_count !== 5'd1) begin n_bad++; $display("FAIL b2b_count%0d got=%0d exp=1", k, trace_count); end
    end
    n_cmp++; if (trace_overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf got=%b exp=0", trace_overflow); end
    stop = 1'b1;
    n_cmp++; if (cpu_en !== 1'b1) begin n_bad++; $display("FAIL stop_cycle_en got=%b exp=1", cpu_en); end
    tick();
    n_cmp++; if (state !== 2'b11) begin n_bad++; $display("FAIL stop_state got=%b exp=11", state); end
    n_cmp++; if (cycle_count !== 16'd6) begin n_bad++; $display("FAIL stop_count got=%0d exp=6", cycle_count); end
    n_cmp++; if (trace_count !== 5'd2) begin n_bad++; $display("FAIL stop_tcount got=%0d exp=2", trace_count); end
    clear = 1'b1; tick();
  endtask

  task automatic test_breakpoint();
    pc = 32'd0; instruction = instr_of(pc); max_cycles = 16'd0;
    bp_addr = {32'h0000_0000, 32'h0000_0010}; bp_valid = 2'b01;
`ifdef RUN_TRACE_BP_EN
    start = 1'b1; tick();
    run_until_halt(20);
    n_cmp++; if (pc !== 32'h10) begin n_bad++; $display("FAIL bp_pc got=%h exp=00000010", pc); end
    n_cmp++; if (cycle_count !== 16'd4) begin n_bad++; $display("FAIL bp_count got=%0d exp=4", cycle_count); end
    n_cmp++; if (bp_hit !== 1'b1) begin n_bad++; $display("FAIL bp_hit got=%b exp=1", bp_hit); end
    start = 1'b1; tick();
    n_cmp++; if (bp_hit !== 1'b0) begin n_bad++; $display("FAIL bp_resume_hit got=%b exp=0", bp_hit); end
    n_cmp++; if (cpu_en !== 1'b1) begin n_bad++; $display("FAIL bp_resume_en got=%b exp=1", cpu_en); end
    tick();
    n_cmp++; if (pc !== 32'h14) begin n_bad++; $display("FAIL bp_resume_pc got=%h exp=00000014", pc); end
    n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL bp_resume_state got=%b exp=01", state); end
    n_cmp++; if (cycle_count !== 16'd5) begin n_bad++; $display("FAIL bp_resume_count got=%0d exp=5", cycle_count); end
`else
    start = 1'b1; tick();
    repeat (6) tick();
    n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL nobp_state got=%b exp=01", state); end
    n_cmp++; if (bp_hit !== 1'b0) begin n_bad++; $display("FAIL nobp_hit got=%b exp=0", bp_hit); end
    n_cmp++; if (cycle_count !== 16'd6) begin n_bad++; $display("FAIL nobp_count got=%0d exp=6", cycle_count); end
`endif
    stop = 1'b1; tick();
    clear = 1'b1; tick();
    bp_valid = 2'b00;
  endtask

  task automatic test_stop_clear();
    pc = 32'd0; instruction = instr_of(pc); max_cycles = 16'd0;
    start = 1'b1; tick();
    tick(); tick();
    stop = 1'b1; clear = 1'b1; tick();
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL sc_state got=%b exp=00", state); end
    n_cmp++; if (cycle_count !== 16'd0) begin n_bad++; $display("FAIL sc_count got=%0d exp=0", cycle_count); end
    n_cmp++; if (trace_empty !== 1'b1) begin n_bad++; $display("FAIL sc_empty got=%b exp=1", trace_empty); end
    n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL sc_en got=%b exp=0", cpu_en); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; step = 1'b0; stop = 1'b0; clear = 1'b0;
    max_cycles = '0; pc = '0; instruction = instr_of(32'd0);
    bp_addr = '0; bp_valid = '0; trace_rd_en = 1'b0;
    test_reset();
    test_limit();
    test_step();
    test_overflow();
    test_back_to_back();
    test_breakpoint();
    test_stop_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
